vx_mem_req_tagger: RTL and testbench

VX_MEM_REQ_TAGGER -- requirements
Module: VX_mem_req_tagger

---
 rtl/vx_mem_req_tagger.sv | 151 +++++++++++++++
 tb/tb_vx_mem_req_tagger.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_req_tagger.sv
// vx_mem_req_tagger: this block translates core-side read tags into small memory-side slot
// indices. Reads take the lowest free slot and store the core tag in it. Writes pass
// through with memory tag 0. Read responses are looked up combinationally, and their
// slot is freed when the core accepts the response.
// Optional feature: define VX_MEM_REQ_TAGGER_PERF_EN to add the perf_read_stalls
// counter port.
//
// Handshake semantics: a transfer happens on a rising edge when valid && ready are
// both high. A valid source holds valid and all payload fields stable until the
// transfer. Ready may depend combinationally on valid, but valid never depends on ready.
module vx_mem_req_tagger #(
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 26,
  parameter int TAG_WIDTH   = 8,
  parameter int NUM_ENTRIES = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  // upstream request
  input  logic                            core_req_valid,
  input  logic                            core_req_rw,
  input  logic [DATA_WIDTH/8-1:0]         core_req_byteen,
  input  logic [ADDR_WIDTH-1:0]           core_req_addr,
  input  logic [DATA_WIDTH-1:0]           core_req_data,
  input  logic [TAG_WIDTH-1:0]            core_req_tag,
  output logic                            core_req_ready,
  // downstream request
  output logic                            mem_req_valid,
  output logic                            mem_req_rw,
  output logic [DATA_WIDTH/8-1:0]         mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0]           mem_req_data,
  output logic [$clog2(NUM_ENTRIES)-1:0]  mem_req_tag,
  input  logic                            mem_req_ready,
  // memory read response
  input  logic                            mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]           mem_rsp_data,
  input  logic [$clog2(NUM_ENTRIES)-1:0]  mem_rsp_tag,
  output logic                            mem_rsp_ready,
  // core read response
  output logic                            core_rsp_valid,
  output logic [DATA_WIDTH-1:0]           core_rsp_data,
  output logic [TAG_WIDTH-1:0]            core_rsp_tag,
  input  logic                            core_rsp_ready,
  // occupancy
  output logic [$clog2(NUM_ENTRIES):0]    inflight_count
`ifdef VX_MEM_REQ_TAGGER_PERF_EN
  ,
  output logic [31:0]                     perf_read_stalls
`endif
);

  localparam int MTAG_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] slot_valid;
  logic [TAG_WIDTH-1:0]   slot_tag [NUM_ENTRIES];

  logic              any_free;
  logic [MTAG_W-1:0] alloc_idx;
  logic              stage_ready;
  logic              req_fire;
  logic              alloc_fire;
  logic              rsp_fire;
  logic              free_fire;
  logic [NUM_ENTRIES-1:0] alloc_mask;
  logic [NUM_ENTRIES-1:0] free_mask;
  logic [MTAG_W:0]   count_next;

  // Lowest-index free slot, taken from the registered valid vector only. A slot freed
  // in this cycle is still marked valid here, so it cannot be reused until next cycle.
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        alloc_idx = MTAG_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  // Request/response handshakes and the slot-table update masks.
  always_comb begin
    stage_ready    = !mem_req_valid || mem_req_ready;
    core_req_ready = stage_ready && (core_req_rw || any_free);
    req_fire       = core_req_valid && core_req_ready;
    alloc_fire     = req_fire && !core_req_rw;
    rsp_fire       = mem_rsp_valid && core_rsp_ready;
    free_fire      = rsp_fire && slot_valid[mem_rsp_tag];
    alloc_mask     = alloc_fire ? (NUM_ENTRIES'(1) << alloc_idx) : '0;
    free_mask      = free_fire  ? (NUM_ENTRIES'(1) << mem_rsp_tag) : '0;
    count_next     = inflight_count + (MTAG_W+1)'(alloc_fire) - (MTAG_W+1)'(free_fire);
  end

  // Responses bypass the slot table. Only the core tag is looked up.
  always_comb begin
    core_rsp_valid = mem_rsp_valid;
    core_rsp_data  = mem_rsp_data;
    core_rsp_tag   = slot_tag[mem_rsp_tag];
    mem_rsp_ready  = core_rsp_ready;
  end

  // Control state: slot valid bits, occupancy and the output stage valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid     <= '0;
      inflight_count <= '0;
      mem_req_valid  <= 1'b0;
    end else begin
      slot_valid     <= (slot_valid | alloc_mask) & ~free_mask;
      inflight_count <= count_next;
      if (stage_ready) mem_req_valid <= req_fire;
    end
  end

  // Payload of the output stage. It only loads on acceptance, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      mem_req_rw     <= core_req_rw;
      mem_req_byteen <= core_req_byteen;
      mem_req_addr   <= core_req_addr;
      mem_req_data   <= core_req_data;
      mem_req_tag    <= core_req_rw ? '0 : alloc_idx;
    end
  end

  // Capture the core tag into the slot that was just allocated.
  always_ff @(posedge clk) begin
    if (alloc_fire) slot_tag[alloc_idx] <= core_req_tag;
  end

`ifndef SYNTHESIS
  // A response must address a slot that holds an outstanding read.
  always @(posedge clk) begin
    if (reset_n && rsp_fire) assert (slot_valid[mem_rsp_tag]);
  end
`endif

`ifdef VX_MEM_REQ_TAGGER_PERF_EN
  // Count the cycles in which a read is presented but held off; the count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_read_stalls <= '0;
    end else if (core_req_valid && !core_req_rw && !core_req_ready &&
                 (perf_read_stalls != 32'hFFFF_FFFF)) begin
      perf_read_stalls <= perf_read_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_req_tagger.sv
// tb_vx_mem_req_tagger: directed scenarios and a short random phase for vx_mem_req_tagger.
// Expected downstream requests are queued as they are accepted, then popped when the
// memory side completes a handshake. A small slot model predicts tags and occupancy.
module tb_vx_mem_req_tagger;

  localparam int DW = 512;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int NE = 8;
  localparam int MW = 3;
  localparam int EW = 1 + AW + MW + 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              core_req_valid, core_req_rw, core_req_ready;
  logic [DW/8-1:0]   core_req_byteen;
  logic [AW-1:0]     core_req_addr;
  logic [DW-1:0]     core_req_data;
  logic [TW-1:0]     core_req_tag;
  logic              mem_req_valid, mem_req_rw, mem_req_ready;
  logic [DW/8-1:0]   mem_req_byteen;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_data;
  logic [MW-1:0]     mem_req_tag;
  logic              mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]     mem_rsp_data;
  logic [MW-1:0]     mem_rsp_tag;
  logic              core_rsp_valid, core_rsp_ready;
  logic [DW-1:0]     core_rsp_data;
  logic [TW-1:0]     core_rsp_tag;
  logic [MW:0]       inflight_count;
`ifdef VX_MEM_REQ_TAGGER_PERF_EN
  logic [31:0]       perf_read_stalls;
`endif

  logic [EW-1:0]     exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  bit                mdl_valid [NE];
  logic [TW-1:0]     mdl_tag [NE];

  vx_mem_req_tagger #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_byteen(core_req_byteen),
    .core_req_addr(core_req_addr), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_byteen(mem_req_byteen),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
    .core_rsp_ready(core_rsp_ready),
    .inflight_count(inflight_count)
`ifdef VX_MEM_REQ_TAGGER_PERF_EN
    , .perf_read_stalls(perf_read_stalls)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NE; i++) if (!mdl_valid[i]) return i;
    return -1;
  endfunction

  function automatic int mdl_count();
    int c = 0;
    for (int i = 0; i < NE; i++) if (mdl_valid[i]) c++;
    return c;
  endfunction

  function automatic int pick_alloc();
    int idx[$];
    for (int i = 0; i < NE; i++) if (mdl_valid[i]) idx.push_back(i);
    if (idx.size() == 0) return -1;
    return idx[$urandom_range(0, idx.size() - 1)];
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Scoreboard side: every downstream handshake must match the oldest queued request.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset_n && mem_req_valid && mem_req_ready) begin
      if (exp_q.size() == 0) begin
        check("mem_req_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("mem_req", 64'({mem_req_rw, mem_req_addr, mem_req_tag, mem_req_data[31:0]}), 64'(e));
        check("mem_req_byteen", 64'(mem_req_byteen), {64{1'b1}});
      end
    end
  end

  // Driver: call just after a rising edge. It returns just after the accepting edge.
  task automatic send_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    int  slot;
    bit  done = 0;
    core_req_valid  = 1'b1;
    core_req_rw     = rw;
    core_req_addr   = addr;
    core_req_tag    = tag;
    core_req_byteen = '1;
    core_req_data   = rand_data();
    for (int b = 0; b < 200 && !done; b++) begin
      @(negedge clk);
      if (core_req_ready) begin
        slot = rw ? 0 : lowest_free();
        if (slot < 0) slot = 0;
        exp_q.push_back({rw, addr, MW'(slot), core_req_data[31:0]});
        @(posedge clk);
        if (!rw) begin
          mdl_valid[slot] = 1'b1;
          mdl_tag[slot]   = tag;
        end
        #1;
        done = 1;
      end
    end
    if (!done) begin
      check("req_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    core_req_valid = 1'b0;
  endtask

  // Driver: call just after a rising edge. The response is presented for one cycle.
  task automatic send_rsp(input logic [MW-1:0] mtag, input logic [DW-1:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = mtag;
    mem_rsp_data  = d;
    @(negedge clk);
    check("core_rsp_valid", 64'(core_rsp_valid), 64'd1);
    check("core_rsp_tag", 64'(core_rsp_tag), 64'(mdl_tag[mtag]));
    check("core_rsp_data", core_rsp_data[63:0], d[63:0]);
    check("mem_rsp_ready", 64'(mem_rsp_ready), 64'(core_rsp_ready));
    @(posedge clk);
    mdl_valid[mtag] = 1'b0;
    #1;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic check_count(input string name);
    check(name, 64'(inflight_count), 64'(mdl_count()));
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic free_all();
    int s;
    s = pick_alloc();
    while (s >= 0) begin
      send_rsp(MW'(s), rand_data());
      s = pick_alloc();
    end
  endtask

  initial begin
    int s;
    reset_n = 1'b0;
    core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_byteen = '0; core_req_addr = '0;
    core_req_data = '0; core_req_tag = '0;
    mem_req_ready = 1'b1; core_rsp_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
    for (int i = 0; i < NE; i++) begin mdl_valid[i] = 1'b0; mdl_tag[i] = '0; end

    // reset state and the first cycle after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_inflight", 64'(inflight_count), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_core_req_ready", 64'(core_req_ready), 64'd1);

    // single read, then its response
    send_req(1'b0, 26'h100, 8'h5A);
    check("single_mem_req_valid", 64'(mem_req_valid), 64'd1);
    check("single_mem_req_tag", 64'(mem_req_tag), 64'd0);
    check("single_inflight", 64'(inflight_count), 64'd1);
    wait_drain("single_drain");
    send_rsp(3'd0, rand_data());
    check("single_inflight_after", 64'(inflight_count), 64'd0);

    // fill all slots, ninth read stalls until slot 3 is freed
    for (int t = 1; t <= 8; t++) send_req(1'b0, AW'(26'h1000 + t), TW'(t));
    check("full_inflight", 64'(inflight_count), 64'd8);
    fork
      send_req(1'b0, 26'h1009, 8'd9);
      begin
        repeat (3) @(negedge clk);
        check("full_read_stall", 64'(core_req_ready), 64'd0);
        check("full_inflight_hold", 64'(inflight_count), 64'd8);
        @(posedge clk); #1;
        send_rsp(3'd3, rand_data());
      end
    join
    check("ninth_got_slot3", 64'(mdl_valid[3] && mdl_tag[3] == 8'd9), 64'd1);
    wait_drain("fill_drain");
    check_count("refill_inflight");

    // write while the table is full
    send_req(1'b1, 26'h40, 8'hEE);
    wait_drain("full_write_drain");
    check("full_write_inflight", 64'(inflight_count), 64'd8);

    // downstream stall holds the output stage
    free_all();
    check_count("freed_inflight");
    mem_req_ready = 1'b0;
    send_req(1'b0, 26'h200, 8'h11);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", 64'(mem_req_valid), 64'd1);
      check("stall_fields", 64'({mem_req_rw, mem_req_addr, mem_req_tag}), 64'({1'b0, 26'h200, 3'd0}));
      check("stall_core_ready", 64'(core_req_ready), 64'd0);
      check("stall_inflight", 64'(inflight_count), 64'd1);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    wait_drain("stall_drain");

    // same-cycle allocate and free
    send_req(1'b0, 26'h201, 8'h21);
    send_req(1'b0, 26'h202, 8'h22);
    check("pre_same_inflight", 64'(inflight_count), 64'd3);
    fork
      send_req(1'b0, 26'h203, 8'h31);
      send_rsp(3'd2, rand_data());
    join
    check("same_cycle_inflight", 64'(inflight_count), 64'd3);
    check("same_cycle_slot3", 64'(mdl_valid[3]), 64'd1);
    send_req(1'b0, 26'h204, 8'h32);
    wait_drain("same_drain");
    check_count("reuse_inflight");

    // reset with slots outstanding and a stalled downstream write
    mem_req_ready = 1'b0;
    send_req(1'b1, 26'h250, 8'h00);
    reset_n = 1'b0;
    #1;
    check("midrst_inflight", 64'(inflight_count), 64'd0);
    check("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    exp_q.delete();
    for (int i = 0; i < NE; i++) mdl_valid[i] = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_core_ready", 64'(core_req_ready), 64'd1);
`ifdef VX_MEM_REQ_TAGGER_PERF_EN
    check("postrst_perf", 64'(perf_read_stalls), 64'd0);
`endif
    send_req(1'b0, 26'h300, 8'h77);
    check("postrst_tag", 64'(mem_req_tag), 64'd0);
    wait_drain("postrst_drain");

    // random mix of reads, writes and responses
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: send_req(1'b1, AW'($urandom), TW'($urandom));
        1: begin
          if (lowest_free() >= 0) send_req(1'b0, AW'($urandom), TW'($urandom));
          else send_req(1'b1, AW'($urandom), TW'($urandom));
        end
        default: begin
          s = pick_alloc();
          if (s >= 0) send_rsp(MW'(s), rand_data());
          else send_req(1'b0, AW'($urandom), TW'($urandom));
        end
      endcase
      check_count("rand_inflight");
    end
    wait_drain("rand_drain");
    free_all();
    check_count("final_inflight");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
